// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM with memory wait timeout.
// Optional feature: define ADDI_EN to decode addi (opcode 001000).
module mc_main_control #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_st;
    logic              timeout;

    assign state = state_q;

    // States that wait on the memory handshake, and the timeout condition
    assign mem_st  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout = mem_st && !mem_ready && (WAIT_LIMIT != 0) && (wait_q == LIMIT);

    // Next state and all control outputs, decoded from the current state
    always_comb begin
        state_d    = state_q;
        alu_op     = 4'b0000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 4'b0010;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 4'b0010;
                case (opcode)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 4'b0010;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100100: alu_op = 4'b0000;
                    6'b100101: alu_op = 4'b0001;
                    6'b100000: alu_op = 4'b0010;
                    6'b100010: alu_op = 4'b0110;
                    6'b101010: alu_op = 4'b0111;
                    default:   alu_op = 4'b0010;
                endcase
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 4'b0110;
                pc_source = 2'b01;
                pc_en     = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 4'b0010;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Wait counter: restarts on any state change, completion or timeout; saturates
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || mem_ready || timeout) begin
            wait_d = '0;
        end else if (mem_st && (wait_q != '1)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule
